// File: rtl/moore_rr_arbiter.sv
// Four-requester round-robin arbiter built as a Moore FSM (IDLE -> GRANT -> RELEASE).
// Optional hold-limit forced release is enabled by defining ARB_HOLD_TIMEOUT_EN.
module moore_rr_arbiter #(
    parameter int unsigned MAX_HOLD = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] req,
    input  logic [3:0] done,
    output logic [3:0] gnt,
    output logic [1:0] gnt_id,
    output logic       busy,
    output logic       timeout
);

    if (MAX_HOLD < 2 || MAX_HOLD > 255) begin : g_bad_max_hold
        $error("moore_rr_arbiter: MAX_HOLD must be in 2..255");
    end

    typedef enum logic [1:0] {
        IDLE    = 2'b00,
        GRANT   = 2'b01,
        RELEASE = 2'b10,
        BAD     = 2'b11
    } state_t;

    state_t     state, state_nxt;
    logic [1:0] ptr, ptr_nxt;
    logic [1:0] owner, owner_nxt;
    logic [1:0] pick, idx;
    logic       pick_vld;
    logic       rel_normal;
    logic       expire;

    // Scan downward so the requester closest to ptr is written last and wins.
    always_comb begin
        pick_vld = 1'b0;
        pick     = ptr;
        idx      = ptr;
        for (int i = 3; i >= 0; i--) begin
            idx = ptr + 2'(i);
            if (req[idx]) begin
                pick_vld = 1'b1;
                pick     = idx;
            end
        end
    end

    assign rel_normal = done[owner] | ~req[owner];

`ifdef ARB_HOLD_TIMEOUT_EN
    logic [7:0] hold_cnt;
    logic       to_flag;

    assign expire = (hold_cnt == 8'(MAX_HOLD - 1));

    // Counter is zero on every GRANT entry since it clears in all other states.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hold_cnt <= 8'd0;
            to_flag  <= 1'b0;
        end else begin
            hold_cnt <= (state == GRANT) ? hold_cnt + 8'd1 : 8'd0;
            to_flag  <= (state == GRANT) && expire && !rel_normal;
        end
    end

    assign timeout = (state == RELEASE) && to_flag;
`else
    assign expire  = 1'b0;
    assign timeout = 1'b0;
`endif

    always_comb begin
        state_nxt = state;
        owner_nxt = owner;
        ptr_nxt   = ptr;
        case (state)
            IDLE: begin
                if (pick_vld) begin
                    owner_nxt = pick;
                    state_nxt = GRANT;
                end
            end
            GRANT: begin
                if (rel_normal || expire) begin
                    ptr_nxt   = owner + 2'd1;
                    state_nxt = RELEASE;
                end
            end
            RELEASE: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
            ptr   <= 2'd0;
            owner <= 2'd0;
        end else begin
            state <= state_nxt;
            ptr   <= ptr_nxt;
            owner <= owner_nxt;
        end
    end

    // Outputs decode registered state only; reset clears them without a clock.
    assign busy   = (state == GRANT);
    assign gnt    = busy ? (4'b0001 << owner) : 4'b0000;
    assign gnt_id = busy ? owner : 2'd0;

endmodule

// File: tb/tb_moore_rr_arbiter.sv
// Directed bench for moore_rr_arbiter: reset, latency, done filtering, async reset,
// round-robin order, single-cycle grant and the hold-limit behaviour of the build.
module tb_moore_rr_arbiter;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] req;
    logic [3:0] done;
    logic [3:0] gnt;
    logic [1:0] gnt_id;
    logic       busy;
    logic       timeout;

    int total  = 0;
    int passed = 0;

    moore_rr_arbiter #(.MAX_HOLD(8)) dut (
        .clk     (clk),
        .rst     (rst),
        .req     (req),
        .done    (done),
        .gnt     (gnt),
        .gnt_id  (gnt_id),
        .busy    (busy),
        .timeout (timeout)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    logic [3:0] order [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    int bad;

    initial begin
        rst = 1'b0; req = 4'b0000; done = 4'b0000;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_gnt", 32'(gnt), 32'h0);
        chk("rst_gnt_id", 32'(gnt_id), 32'h0);
        chk("rst_busy", 32'(busy), 32'h0);
        chk("rst_timeout", 32'(timeout), 32'h0);
        rst = 1'b1;

        // single requester 2: one-edge latency, foreign done/req ignored
        req = 4'b0100;
        step();
        chk("lat_gnt", 32'(gnt), 32'h4);
        chk("lat_gnt_id", 32'(gnt_id), 32'h2);
        chk("lat_busy", 32'(busy), 32'h1);
        req = 4'b1111; done = 4'b1011;
        step();
        chk("ign_done1", 32'(gnt), 32'h4);
        step();
        chk("ign_done2", 32'(gnt), 32'h4);
        req = 4'b0100; done = 4'b0100;
        step();
        chk("rel_gnt", 32'(gnt), 32'h0);
        chk("rel_busy", 32'(busy), 32'h0);
        chk("rel_timeout", 32'(timeout), 32'h0);
        done = 4'b0000; req = 4'b0000;
        step();
        chk("idle_gnt", 32'(gnt), 32'h0);

        // ptr is now 3; grant 2, then reset asynchronously mid-cycle
        req = 4'b0100;
        step();
        chk("pre_rst_gnt", 32'(gnt), 32'h4);
        req = 4'b1111;
        #2 rst = 1'b0;
        #1;
        chk("async_rst_gnt", 32'(gnt), 32'h0);
        chk("async_rst_busy", 32'(busy), 32'h0);
        step();
        chk("in_rst_gnt", 32'(gnt), 32'h0);
        rst = 1'b1;
        step();

        // req=1111 held: order restarts at 0 and rotates, done after 2 GRANT cycles
        for (int i = 0; i < 5; i++) begin
            chk($sformatf("rr%0d_gnt_c1", i), 32'(gnt), 32'(order[i]));
            chk($sformatf("rr%0d_gnt_id", i), 32'(gnt_id), 32'(i % 4));
            step();
            chk($sformatf("rr%0d_gnt_c2", i), 32'(gnt), 32'(order[i]));
            done = order[i];
            step();
            chk($sformatf("rr%0d_release", i), 32'({busy, gnt}), 32'h0);
            done = 4'b0000;
            if (i == 4) req = 4'b0000;
            step();
            chk($sformatf("rr%0d_idle", i), 32'(gnt), 32'h0);
            step();
        end

        // ptr is now 1; requester 1 drops req right after grant but still gets one cycle
        req = 4'b0010;
        step();
        chk("short_gnt", 32'(gnt), 32'h2);
        req = 4'b0000;
        step();
        chk("short_release", 32'(gnt), 32'h0);
        step();

`ifdef ARB_HOLD_TIMEOUT_EN
        req = 4'b0001;
        step();
        bad = 0;
        for (int c = 0; c < 8; c++) begin
            if (gnt !== 4'b0001 || timeout !== 1'b0) bad++;
            step();
        end
        chk("hold_8_cycles", 32'(bad), 32'h0);
        chk("to_release_gnt", 32'(gnt), 32'h0);
        chk("to_flag", 32'(timeout), 32'h1);
        step();
        chk("to_flag_clear", 32'(timeout), 32'h0);
        step();
        chk("to_regrant", 32'(gnt), 32'h1);
        repeat (7) step();
        chk("expiry_cycle_gnt", 32'(gnt), 32'h1);
        done = 4'b0001;
        step();
        chk("expiry_done_gnt", 32'(gnt), 32'h0);
        chk("expiry_done_to", 32'(timeout), 32'h0);
        done = 4'b0000; req = 4'b0000;
        step();
`else
        req = 4'b0001;
        step();
        bad = 0;
        for (int c = 0; c < 120; c++) begin
            if (gnt !== 4'b0001 || timeout !== 1'b0) bad++;
            step();
        end
        chk("unbounded_hold", 32'(bad), 32'h0);
        chk("unbounded_gnt", 32'(gnt), 32'h1);
        req = 4'b0000;
        step();
        chk("unbounded_release", 32'(gnt), 32'h0);
`endif

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
